// File: rtl/sp_vec_unpacker_if.sv
// x_if: one vector of K complex I/Q samples per valid beat; the producer has no backpressure.
interface x_if #(parameter int K = 7, parameter int LEN = 16);
    logic valid;
    logic [K*2*LEN-1:0] value;
    modport in (input valid, value);
    modport out (output valid, value);
endinterface

// File: rtl/sp_vec_unpacker.sv
// sp_vec_unpacker: buffers up to DEPTH I/Q vectors and streams them one sample per cycle, element 0 first.
module sp_vec_unpacker #(
    parameter int K = 7,
    parameter int LEN = 16,
    parameter int DEPTH = 2,
    localparam int IW = (K > 1) ? $clog2(K) : 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    x_if.in                       xin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [LEN-1:0] out_i,
    output logic signed [LEN-1:0] out_q,
    output logic [IW-1:0]         out_idx,
    output logic                  out_last,
    input  logic                  clr_ovf,
    output logic                  overflow,
    output logic [7:0]            drop_cnt,
    output logic [CW-1:0]         level
);
    typedef enum logic {EMPTY, STREAM} state_t;
    state_t state, state_nxt;
    logic [K-1:0][2*LEN-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic [2*LEN-1:0] elem;
    logic hs, pop, push, drop;
    assign hs = out_valid && out_ready;
    assign pop = hs && idx == IW'(K - 1);
    assign push = xin.valid && (count < CW'(DEPTH) || pop);
    assign drop = xin.valid && count == CW'(DEPTH) && !pop;
    assign elem = mem[rd_ptr][idx];
    assign out_valid = state == STREAM;
    assign out_i = out_valid ? elem[2*LEN-1:LEN] : '0;
    assign out_q = out_valid ? elem[LEN-1:0] : '0;
    assign out_idx = idx;
    assign out_last = out_valid && idx == IW'(K - 1);
    assign level = count;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == EMPTY)
            state_nxt = push ? STREAM : EMPTY;
        else if (pop && count == CW'(1) && !push)
            state_nxt = EMPTY;
    end
    // Storage is not reset; it is don't-care while count==0.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= xin.value;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            idx <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (hs) idx <= pop ? '0 : idx + IW'(1);
            // A drop in the same cycle as clr_ovf wins and restarts the count at 1.
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
            drop_cnt <= drop ? (clr_ovf ? 8'd1 : (drop_cnt == 8'hff ? 8'hff : drop_cnt + 8'd1))
                      : clr_ovf ? 8'd0 : drop_cnt;
        end
    end
endmodule

// File: tb/tb_sp_vec_unpacker.sv
// tb_sp_vec_unpacker: directed scenarios plus random traffic checked against a queue-based model.
module tb_sp_vec_unpacker;
    localparam int K = 7;
    localparam int LEN = 16;
    localparam int DEPTH = 2;
    localparam int VW = K * 2 * LEN;
    logic clk = 1'b0;
    logic rst_n;
    logic out_valid, out_ready, out_last, clr_ovf, overflow;
    logic signed [LEN-1:0] out_i, out_q;
    logic [2:0] out_idx;
    logic [7:0] drop_cnt;
    logic [1:0] level;
    int checks = 0;
    int errors = 0;
    logic [VW-1:0] mq[$];
    int midx = 0;
    logic movf = 1'b0;
    int mdc = 0;
    x_if #(.K(K), .LEN(LEN)) xin();
    sp_vec_unpacker #(.K(K), .LEN(LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .xin(xin), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_idx(out_idx), .out_last(out_last),
        .clr_ovf(clr_ovf), .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [VW-1:0] ramp_vec(input int base);
        logic [VW-1:0] v;
        for (int j = 0; j < K; j++) begin
            v[j*2*LEN+LEN +: LEN] = LEN'(base + j + 1);
            v[j*2*LEN +: LEN] = LEN'(-(base + j + 1));
        end
        return v;
    endfunction
    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < K; j++) v[j*2*LEN +: 2*LEN] = (2*LEN)'($urandom);
        return v;
    endfunction
    task automatic check_outputs();
        logic [VW-1:0] h;
        logic ev;
        logic signed [LEN-1:0] ei, eq;
        ev = mq.size() != 0;
        h = ev ? mq[0] : '0;
        ei = ev ? h[midx*2*LEN+LEN +: LEN] : '0;
        eq = ev ? h[midx*2*LEN +: LEN] : '0;
        chk("valid", 32'(out_valid), 32'(ev));
        chk("i", 32'(out_i), 32'(ei));
        chk("q", 32'(out_q), 32'(eq));
        chk("idx", 32'(out_idx), 32'(midx));
        chk("last", 32'(out_last), 32'(ev && midx == K - 1));
        chk("level", 32'(level), 32'(mq.size()));
        chk("ovf", 32'(overflow), 32'(movf));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdc));
    endtask
    task automatic cycle(input logic v, input logic [VW-1:0] d, input logic r, input logic c, input logic rn);
        logic hs, pop, acc, drp;
        xin.valid = v;
        xin.value = d;
        out_ready = r;
        clr_ovf = c;
        rst_n = rn;
        check_outputs();
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            midx = 0;
            movf = 1'b0;
            mdc = 0;
        end else begin
            hs = mq.size() != 0 && r;
            pop = hs && midx == K - 1;
            acc = v && (mq.size() < DEPTH || pop);
            drp = v && !acc;
            if (pop) begin
                void'(mq.pop_front());
                midx = 0;
            end else if (hs) midx++;
            if (acc) mq.push_back(d);
            if (drp) begin
                movf = 1'b1;
                mdc = c ? 1 : (mdc < 255 ? mdc + 1 : 255);
            end else if (c) begin
                movf = 1'b0;
                mdc = 0;
            end
        end
        @(negedge clk);
    endtask
    initial begin
        xin.valid = 1'b0;
        xin.value = '0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        cycle(1'b1, ramp_vec(0), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        // single vector streamed with ready held high
        cycle(1'b1, ramp_vec(0), 1'b1, 1'b0, 1'b1);
        chk("t1_first_i", 32'(out_i), 32'd1);
        chk("t1_first_q", 32'(out_q), 32'hffff_ffff);
        for (int n = 0; n < 9; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t1_drained", 32'(level), 32'd0);
        // backpressure with alternating ready
        cycle(1'b1, ramp_vec(10), 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 16; n++) cycle(1'b0, '0, 1'(n % 2 == 0), 1'b0, 1'b1);
        chk("t2_ovf", 32'(overflow), 32'd0);
        // three back-to-back vectors with ready low
        for (int n = 0; n < 3; n++) cycle(1'b1, ramp_vec(20 * (n + 1)), 1'b0, 1'b0, 1'b1);
        chk("t3_level", 32'(level), 32'd2);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        chk("t3_head_i", 32'(out_i), 32'd21);
        for (int n = 0; n < 15; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        // full buffer with a push on the head's final handshake
        cycle(1'b1, ramp_vec(100), 1'b0, 1'b1, 1'b1);
        cycle(1'b1, ramp_vec(200), 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t4_last", 32'(out_last), 32'd1);
        cycle(1'b1, ramp_vec(300), 1'b1, 1'b0, 1'b1);
        chk("t4_level", 32'(level), 32'd2);
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_drop", 32'(drop_cnt), 32'd0);
        chk("t4_head_i", 32'(out_i), 32'd201);
        // saturation and clear
        for (int n = 0; n < 300; n++) cycle(1'b1, rand_vec(), 1'b0, 1'b0, 1'b1);
        chk("t5_sat", 32'(drop_cnt), 32'd255);
        cycle(1'b1, rand_vec(), 1'b0, 1'b1, 1'b1);
        chk("t5_race_ovf", 32'(overflow), 32'd1);
        chk("t5_race_cnt", 32'(drop_cnt), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("t5_clr_ovf", 32'(overflow), 32'd0);
        chk("t5_clr_cnt", 32'(drop_cnt), 32'd0);
        // reset in the middle of a vector
        for (int n = 0; n < 3; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t6_idx", 32'(out_idx), 32'd3);
        cycle(1'b1, rand_vec(), 1'b1, 1'b0, 1'b0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        cycle(1'b1, ramp_vec(500), 1'b1, 1'b0, 1'b1);
        chk("t6_idx0", 32'(out_idx), 32'd0);
        chk("t6_i", 32'(out_i), 32'd501);
        for (int n = 0; n < 8; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        // random traffic
        for (int n = 0; n < 3000; n++)
            cycle(1'($urandom_range(0, 5) == 0), rand_vec(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 300) != 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
